// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART transmit path (and later the receiver).
//   tx_state_t        : transmit sequencer states
//   data_bits_t       : encoded character length (5..8 data bits)
//   uart_frame_cfg_t  : frame format, frozen at each frame launch
//   last_bit_idx()    : index of the last data bit for a character length
//   even_parity()     : XOR of the transmitted data bits
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_CHAR_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        DB5 = 2'd0,
        DB6 = 2'd1,
        DB7 = 2'd2,
        DB8 = 2'd3
    } data_bits_t;

    typedef struct packed {
        data_bits_t data_bits;
        logic       parity_en;
        logic       parity_odd;
        logic       stop2;
    } uart_frame_cfg_t;

    // Data bits are numbered 0..N-1, so the last one is N-1 = 4 + encoding.
    function automatic logic [2:0] last_bit_idx(input data_bits_t db);
        return 3'd4 + {1'b0, db};
    endfunction

    // Only the N bits that actually go on the line take part in parity.
    function automatic logic even_parity(input logic [UART_CHAR_W-1:0] data,
                                         input data_bits_t             db);
        logic [UART_CHAR_W-1:0] mask;
        case (db)
            DB5:     mask = 8'h1F;
            DB6:     mask = 8'h3F;
            DB7:     mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        return ^(data & mask);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period down-counter. A bit lasts i_div+1 clocks; o_tick is high in the
// last clock of each period and the counter reloads itself from i_div there,
// so consecutive bits chain without gaps. i_reload restarts a period.
//   i_clk    in  clock
//   i_nrst   in  async reset, active low
//   i_reload in  force the counter to i_div (start of a new bit stream)
//   i_div    in  bit period minus one, in clocks
//   o_tick   out last clock of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_reload,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    assign o_tick = (r_cnt == {DIV_W{1'b0}});

    // Period counter: reload on request or at the end of each period.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_cnt <= {DIV_W{1'b0}};
        end else if (i_reload || o_tick) begin
            r_cnt <= i_div;
        end else begin
            r_cnt <= r_cnt - {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// Transmit sequencer between a first-word-fall-through FIFO and the TX pin.
// Pops one word per frame and sends start / 5..8 data (LSB first) /
// optional parity / 1 or 2 stop bits. Frame format and bit period are
// captured at launch and held for the whole frame.
//   i_clk, i_nrst          clock, async active-low reset
//   i_en                   enable; only consulted when a new frame could start
//   i_abort                drop the frame in flight, line back to idle
//   i_baud_div             bit period minus one
//   i_data_bits            0:5 1:6 2:7 3:8 data bits
//   i_parity_en/_odd       parity insertion and sense
//   i_stop2                two stop bits
//   i_fifo_data/_valid     FIFO head word and non-empty flag
//   o_fifo_rd_req          pop strobe, high in the launch cycle
//   o_tx                   serial line (registered, idle high)
//   o_busy                 frame in progress (registered)
//   o_tx_done              high in the final clock of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DW    = 8,
    parameter int BAUD_DIV_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_en,
    input  logic                  i_abort,
    input  logic [BAUD_DIV_W-1:0] i_baud_div,
    input  logic [1:0]            i_data_bits,
    input  logic                  i_parity_en,
    input  logic                  i_parity_odd,
    input  logic                  i_stop2,
    input  logic [FIFO_DW-1:0]    i_fifo_data,
    input  logic                  i_fifo_valid,
    output logic                  o_fifo_rd_req,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_tx_done
);

    tx_state_t             r_state;
    tx_state_t             w_next;
    uart_frame_cfg_t       r_cfg;
    logic [BAUD_DIV_W-1:0] r_baud_div;
    logic [BAUD_DIV_W-1:0] w_div;
    logic [7:0]            r_shift;
    logic [2:0]            r_bit_cnt;
    logic                  r_stop_cnt;
    logic                  r_par_even;
    logic                  r_tx;
    logic                  r_busy;

    logic w_tick;
    logic w_abort;
    logic w_launch_ok;
    logic w_launch;
    logic w_tx_next;
    logic w_done;
    logic w_shift;
    logic w_stop_set;
    logic w_stop_clr;

    // Holding reset also holds off the pop strobe, which is combinational.
    assign w_launch_ok = i_nrst & i_en & i_fifo_valid & ~i_abort;
    assign w_abort     = i_abort & (r_state != IDLE);

    // The first bit period of a frame uses the divider being captured now.
    assign w_div = w_launch ? i_baud_div : r_baud_div;

    uart_baud_tick #(
        .DIV_W (BAUD_DIV_W)
    ) u_baud_tick (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .i_reload (w_launch),
        .i_div    (w_div),
        .o_tick   (w_tick)
    );

    // Next-state, next line level and datapath strobes.
    always_comb begin
        w_next     = r_state;
        w_tx_next  = r_tx;
        w_launch   = 1'b0;
        w_done     = 1'b0;
        w_shift    = 1'b0;
        w_stop_set = 1'b0;
        w_stop_clr = 1'b0;
        if (w_abort) begin
            w_next    = IDLE;
            w_tx_next = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_launch_ok) begin
                        w_launch  = 1'b1;
                        w_next    = START;
                        w_tx_next = 1'b0;
                    end else begin
                        w_next    = IDLE;
                        w_tx_next = 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        w_next    = DATA;
                        w_tx_next = r_shift[0];
                    end else begin
                        w_next = START;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == last_bit_idx(r_cfg.data_bits)) begin
                            if (r_cfg.parity_en) begin
                                w_next    = PARITY;
                                w_tx_next = r_par_even ^ r_cfg.parity_odd;
                            end else begin
                                w_next     = STOP;
                                w_tx_next  = 1'b1;
                                w_stop_clr = 1'b1;
                            end
                        end else begin
                            // Shift happens at this edge, so the next bit is [1].
                            w_shift   = 1'b1;
                            w_tx_next = r_shift[1];
                        end
                    end else begin
                        w_next = DATA;
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        w_next     = STOP;
                        w_tx_next  = 1'b1;
                        w_stop_clr = 1'b1;
                    end else begin
                        w_next = PARITY;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_cfg.stop2 && !r_stop_cnt) begin
                            w_stop_set = 1'b1;
                        end else begin
                            // Final stop clock: report done and maybe chain the next frame.
                            w_done = 1'b1;
                            if (w_launch_ok) begin
                                w_launch  = 1'b1;
                                w_next    = START;
                                w_tx_next = 1'b0;
                            end else begin
                                w_next    = IDLE;
                                w_tx_next = 1'b1;
                            end
                        end
                    end else begin
                        w_next = STOP;
                    end
                end
                default: begin
                    w_next    = IDLE;
                    w_tx_next = 1'b1;
                end
            endcase
        end
    end

    // State, line and busy registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tx    <= w_tx_next;
            r_busy  <= (w_next != IDLE);
        end
    end

    // Frame capture at launch, then shifting and data-bit counting.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_shift    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_par_even <= 1'b0;
            r_baud_div <= {BAUD_DIV_W{1'b0}};
            r_cfg      <= '{data_bits: DB5, parity_en: 1'b0, parity_odd: 1'b0, stop2: 1'b0};
        end else if (w_launch) begin
            r_shift    <= i_fifo_data[7:0];
            r_bit_cnt  <= 3'd0;
            r_par_even <= even_parity(i_fifo_data[7:0], data_bits_t'(i_data_bits));
            r_baud_div <= i_baud_div;
            r_cfg      <= '{data_bits:  data_bits_t'(i_data_bits),
                            parity_en:  i_parity_en,
                            parity_odd: i_parity_odd,
                            stop2:      i_stop2};
        end else if (w_shift) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    // Stop-bit counter: 0 during the first stop bit, 1 during the second.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_stop_cnt <= 1'b0;
        end else if (w_stop_clr) begin
            r_stop_cnt <= 1'b0;
        end else if (w_stop_set) begin
            r_stop_cnt <= 1'b1;
        end
    end

    assign o_fifo_rd_req = w_launch;
    assign o_tx_done     = w_done;
    assign o_tx          = r_tx;
    assign o_busy        = r_busy;

endmodule
